// File: rtl/sched04_pkg.sv
// sched04_pkg: shared definitions for the sample04 scheduled executor.
//   state_t   : controller states (IDLE, S1..S5, DONE)
//   op_t      : functional-unit operation select
//   NUM_STEPS : number of compute steps in the fixed schedule
package sched04_pkg;

  localparam int NUM_STEPS = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    DONE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_NOT = 2'd2
  } op_t;

endpackage

// File: rtl/sched04_fu.sv
// sched04_fu: WIDTH-bit bitwise functional unit.
//   a, b : operands (b is ignored for OP_NOT)
//   op   : operation select (AND / OR / NOT)
//   y    : combinational result
import sched04_pkg::*;

module sched04_fu #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/sched04_exec.sv
// sched04_exec: multi-cycle executor for the sample04 network using one
// shared AND, one OR and one NOT unit over a fixed 5-step schedule.
//   clk, rst            : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (x, y, z, u, v, w)
//   out_valid/out_ready : result handshake (r, s, t)
//   r = (((x&y&z)|u)|w) & (v|x|y),  s = u&w,  t = ~z
//   busy                : high while computing (S1..S5)
//   txn_cnt             : completed output handshakes, wraps
import sched04_pkg::*;

module sched04_exec #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] t,
  output logic             busy,
  output logic [CNT_W-1:0] txn_cnt
);

  state_t state;

  // Captured operands
  logic [WIDTH-1:0] x_reg, y_reg, z_reg, u_reg, v_reg, w_reg;
  // Scratch results, one per scheduled operation
  logic [WIDTH-1:0] n1_reg, m1_reg, tt_reg, n_reg, m_reg;
  logic [WIDTH-1:0] ss_reg, p_reg, q_reg, rr_reg;

  // Functional-unit operand buses
  logic [WIDTH-1:0] and_a, and_b, and_y;
  logic [WIDTH-1:0] or_a, or_b, or_y;
  logic [WIDTH-1:0] not_a, not_y;

  sched04_fu #(.WIDTH(WIDTH)) u_and (.a(and_a), .b(and_b), .op(OP_AND), .y(and_y));
  sched04_fu #(.WIDTH(WIDTH)) u_or  (.a(or_a),  .b(or_b),  .op(OP_OR),  .y(or_y));
  sched04_fu #(.WIDTH(WIDTH)) u_not (.a(not_a), .b('0),    .op(OP_NOT), .y(not_y));

  // Per-step operand routing into the shared units
  always_comb begin
    and_a = '0;
    and_b = '0;
    or_a  = '0;
    or_b  = '0;
    not_a = '0;
    case (state)
      S1: begin
        and_a = x_reg;  and_b = y_reg;
        or_a  = v_reg;  or_b  = x_reg;
        not_a = z_reg;
      end
      S2: begin
        and_a = n1_reg; and_b = z_reg;
        or_a  = m1_reg; or_b  = y_reg;
      end
      S3: begin
        and_a = u_reg;  and_b = w_reg;
        or_a  = n_reg;  or_b  = u_reg;
      end
      S4: begin
        or_a  = p_reg;  or_b  = w_reg;
      end
      S5: begin
        and_a = q_reg;  and_b = m_reg;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == S1) || (state == S2) || (state == S3) ||
                     (state == S4) || (state == S5);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      x_reg   <= '0; y_reg  <= '0; z_reg  <= '0;
      u_reg   <= '0; v_reg  <= '0; w_reg  <= '0;
      n1_reg  <= '0; m1_reg <= '0; tt_reg <= '0;
      n_reg   <= '0; m_reg  <= '0; ss_reg <= '0;
      p_reg   <= '0; q_reg  <= '0; rr_reg <= '0;
      r       <= '0;
      s       <= '0;
      t       <= '0;
      txn_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= x; y_reg <= y; z_reg <= z;
            u_reg <= u; v_reg <= v; w_reg <= w;
            state <= S1;
          end
        end
        S1: begin
          n1_reg <= and_y;
          m1_reg <= or_y;
          tt_reg <= not_y;
          state  <= S2;
        end
        S2: begin
          n_reg <= and_y;
          m_reg <= or_y;
          state <= S3;
        end
        S3: begin
          ss_reg <= and_y;
          p_reg  <= or_y;
          state  <= S4;
        end
        S4: begin
          q_reg <= or_y;
          state <= S5;
        end
        S5: begin
          // rr is produced on this same edge, so the output takes it
          // straight from the AND unit rather than from rr_reg.
          rr_reg <= and_y;
          r      <= and_y;
          s      <= ss_reg;
          t      <= tt_reg;
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            txn_cnt <= txn_cnt + CNT_W'(1);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sched04_exec.sv
// tb_sched04_exec: randomized self-checking bench for sched04_exec with a
// transaction-level reference model and per-cycle output comparison.
module tb_sched04_exec;

  localparam int W   = 4;
  localparam int CW  = 8;
  localparam int LAT = 6;  // edges from the accepting edge to out_valid, inclusive

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  x = '0, y = '0, z = '0, u = '0, v = '0, w = '0;
  logic          in_ready, out_valid, busy;
  logic [W-1:0]  r, s, t;
  logic [CW-1:0] txn_cnt;

  sched04_exec #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .u(u), .v(v), .w(w),
    .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .s(s), .t(t),
    .busy(busy), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_since : edges elapsed since acceptance while computing, -1 otherwise
  // m_hold  : a finished result is waiting for out_ready
  int           m_since = -1;
  bit           m_hold  = 1'b0;
  bit           m_live  = 1'b0;
  int           m_cnt   = 0;
  logic [W-1:0] m_r = '0, m_s = '0, m_t = '0;
  logic [W-1:0] p_r = '0, p_s = '0, p_t = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_since = -1;
      m_hold  = 1'b0;
      m_cnt   = 0;
      m_r = '0; m_s = '0; m_t = '0;
      m_live  = 1'b1;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        m_cnt  = (m_cnt + 1) % (1 << CW);
      end
    end else if (m_since >= 0) begin
      m_since++;
      if (m_since == LAT - 1) begin
        m_since = -1;
        m_hold  = 1'b1;
        m_r = p_r; m_s = p_s; m_t = p_t;
      end
    end else if (in_valid) begin
      m_since = 0;
      p_r = (((x & y & z) | u) | w) & (v | x | y);
      p_s = u & w;
      p_t = ~z;
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready",  {31'b0, in_ready},  {31'b0, (m_since < 0) && !m_hold});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_hold});
      chk("busy",      {31'b0, busy},      {31'b0, m_since >= 0});
      chk("r", 32'(r), 32'(m_r));
      chk("s", 32'(s), 32'(m_s));
      chk("t", 32'(t), 32'(m_t));
      chk("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_ops();
    x = W'($urandom); y = W'($urandom); z = W'($urandom);
    u = W'($urandom); v = W'($urandom); w = W'($urandom);
  endtask

  // Called at posedge+2. Returns at posedge+2 of the first DONE cycle with
  // lat = edges counted from the accepting edge (inclusive).
  task automatic run_txn(input logic [W-1:0] a, b, c, d, e, f,
                         input logic rdy, output int lat);
    int n;
    x = a; y = b; z = c; u = d; v = e; w = f;
    in_valid  = 1'b1;
    out_ready = rdy;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(n), 32'(0));
    tick();
    in_valid = 1'b0;
    rand_ops();  // operands may change freely after acceptance
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  logic [W-1:0] sv_r, sv_s, sv_t;
  int lat;

  initial begin
    // Reset held for two edges
    rst = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_cnt", 32'(txn_cnt), 32'd0);
    rst = 1'b1;

    // x=y=z=1, u=v=w=0
    run_txn(4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, lat);
    chk("latency", 32'(lat), 32'(LAT));
    chk("t1_r", 32'(r), 32'hF);
    chk("t1_s", 32'(s), 32'h0);
    chk("t1_t", 32'(t), 32'h0);
    tick();
    chk("t1_cnt", 32'(txn_cnt), 32'd1);

    // u=w=1, others 0
    run_txn(4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, lat);
    chk("t2_r", 32'(r), 32'h0);
    chk("t2_s", 32'(s), 32'hF);
    chk("t2_t", 32'(t), 32'hF);
    tick();

    // all zero
    run_txn(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, lat);
    chk("t3_r", 32'(r), 32'h0);
    chk("t3_s", 32'(s), 32'h0);
    chk("t3_t", 32'(t), 32'hF);
    tick();

    // multi-bit pattern
    run_txn(4'b1010, 4'b1100, 4'b1111, 4'h0, 4'h0, 4'h0, 1'b1, lat);
    chk("t4_r", 32'(r), 32'h8);
    chk("t4_s", 32'(s), 32'h0);
    chk("t4_t", 32'(t), 32'h0);
    tick();

    // Backpressure: hold DONE for 10 cycles with new operands offered
    run_txn(W'($urandom), W'($urandom), W'($urandom),
            W'($urandom), W'($urandom), W'($urandom), 1'b0, lat);
    sv_r = r; sv_s = s; sv_t = t;
    rand_ops();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_in_ready",  {31'b0, in_ready},  32'd0);
    chk("bp_r", 32'(r), 32'(sv_r));
    chk("bp_s", 32'(s), 32'(sv_s));
    chk("bp_t", 32'(t), 32'(sv_t));
    out_ready = 1'b1;
    tick();  // exit DONE
    chk("bp_idle_ready", {31'b0, in_ready},  32'd1);
    chk("bp_idle_valid", {31'b0, out_valid}, 32'd0);
    tick();  // accepting edge
    chk("bp_accepted", {31'b0, busy}, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    tick();

    // Reset while in S3
    rand_ops();
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    tick();          // accept -> S1
    in_valid = 1'b0;
    tick();          // S2
    tick();          // S3
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_busy",  {31'b0, busy},     32'd0);
    chk("mid_rst_r", 32'(r), 32'd0);
    chk("mid_rst_cnt", 32'(txn_cnt), 32'd0);
    run_txn(4'b1010, 4'b1100, 4'b1111, 4'h0, 4'h0, 4'h0, 1'b1, lat);
    chk("post_rst_r", 32'(r), 32'h8);
    tick();

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 2) != 0;
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 64) != 0;
      rand_ops();
      tick();
    end
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Counter wrap: 256 transactions from a fresh reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      run_txn(W'($urandom), W'($urandom), W'($urandom),
              W'($urandom), W'($urandom), W'($urandom), 1'b1, lat);
      tick();
      if (i == 254) chk("cnt_255", 32'(txn_cnt), 32'd255);
    end
    chk("cnt_wrap", 32'(txn_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
